// File: rtl/keypad_entry_if.sv
// Keypad entry bus: encoder handshake, panel controls and the cook-time
// outputs handed to the countdown timer.
interface keypad_entry_if;
    logic        loadn;        // 0 = key pressed, saida_cod valid
    logic [3:0]  saida_cod;    // encoded key from the encoder
    logic        clear;        // CLEAR key
    logic        lock;         // oven running / door interlock
    logic        enablen;      // 0 = encoder enabled
    logic [15:0] tempo_bcd;    // {min_t, min_u, sec_t, sec_u}
    logic [2:0]  num_digitos;  // digits entered, 0..4
    logic        cheio;        // all four digits entered
    logic        tecla_pulso;  // one-cycle pulse per accepted digit

    // Environment side: encoder, panel and timer.
    modport master (
        output loadn, saida_cod, clear, lock,
        input  enablen, tempo_bcd, num_digitos, cheio, tecla_pulso
    );

    // Controller side.
    modport slave (
        input  loadn, saida_cod, clear, lock,
        output enablen, tempo_bcd, num_digitos, cheio, tecla_pulso
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: synchronises and debounces the encoder loadn
// strobe and shifts each accepted BCD key into a 4-digit MM:SS register.
// A key is captured once per press; a debounced release is needed before
// the next one. clear wipes the entry, lock suspends keypad entry.
module keypad_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,  // stable cycles needed to accept a level
    parameter int CNT_W           = 3   // 2**CNT_W > DEBOUNCE_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    keypad_entry_if.slave  kp
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        CAPTURE,
        WAIT_REL,
        DEB_REL
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchroniser pipes; loadn idles high so its flops reset to 1.
    logic        loadn_s1_q, loadn_s_q;
    logic [3:0]  cod_s1_q,   cod_s_q;
    logic        enablen_q;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [15:0]     tempo_q, tempo_d;
    logic [2:0]      num_q,   num_d;
    logic            pulse_q, pulse_d;

    // Two-flop synchronisers for the encoder outputs and registered encoder enable.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            loadn_s1_q <= 1'b1;
            loadn_s_q  <= 1'b1;
            cod_s1_q   <= 4'd0;
            cod_s_q    <= 4'd0;
            enablen_q  <= 1'b1;
        end else begin
            loadn_s1_q <= kp.loadn;
            loadn_s_q  <= loadn_s1_q;
            cod_s1_q   <= kp.saida_cod;
            cod_s_q    <= cod_s1_q;
            enablen_q  <= kp.lock;
        end
    end

    // FSM state, debounce counter and entered-time registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tempo_q <= 16'h0000;
            num_q   <= 3'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tempo_q <= tempo_d;
            num_q   <= num_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state, debounce counting and digit capture; clear overrides capture.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tempo_d = tempo_q;
        num_d   = num_q;
        pulse_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!loadn_s_q && !kp.lock) begin
                    state_d = DEB_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            DEB_PRESS: begin
                if (kp.lock) begin
                    state_d = WAIT_REL;           // abort, no digit
                end else if (loadn_s_q) begin
                    state_d = IDLE;               // glitch rejected
                end else if (cnt_q == DEB_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CAPTURE: begin
                state_d = WAIT_REL;
                // Non-digit codes and a full register consume the key silently.
                if (!kp.lock && !kp.clear && (cod_s_q <= 4'd9) && (num_q < 3'd4)) begin
                    tempo_d = {tempo_q[11:0], cod_s_q};
                    num_d   = num_q + 3'd1;
                    pulse_d = 1'b1;
                end
            end
            WAIT_REL: begin
                if (loadn_s_q) begin
                    state_d = DEB_REL;
                    cnt_d   = CNT_ONE;
                end
            end
            DEB_REL: begin
                if (!loadn_s_q) begin
                    state_d = WAIT_REL;           // release bounced
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (kp.clear) begin
            tempo_d = 16'h0000;
            num_d   = 3'd0;
        end
    end

    assign kp.enablen     = enablen_q;
    assign kp.tempo_bcd   = tempo_q;
    assign kp.num_digitos = num_q;
    assign kp.cheio       = (num_q == 3'd4);
    assign kp.tecla_pulso = pulse_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl (DEBOUNCE_CYCLES = 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or 1 ns after a rising edge.
module tb_keypad_entry_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulse_cnt = 0;
    int   lat;

    keypad_entry_if bus ();

    keypad_entry_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (bus.slave)
    );

    always #5 clk = ~clk;

    // Count accepted-digit pulses seen on the falling edge.
    always @(negedge clk) begin
        if (bus.tecla_pulso === 1'b1) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press one key for 'hold' cycles, then release for 'rel' cycles.
    task automatic press_key(input logic [3:0] code, input int hold, input int rel);
        bus.loadn     = 1'b0;
        bus.saida_cod = code;
        cycles(hold);
        bus.loadn = 1'b1;
        cycles(rel);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cycles(1);
        bus.clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.loadn     = 1'b0;
        bus.saida_cod = 4'd0;
        bus.clear     = 1'b0;
        bus.lock      = 1'b0;

        // Reset held 3 cycles with a key apparently pressed.
        cycles(3);
        check("rst_tempo",   32'(bus.tempo_bcd),   32'h0);
        check("rst_num",     32'(bus.num_digitos), 32'd0);
        check("rst_cheio",   32'(bus.cheio),       32'd0);
        check("rst_enablen", 32'(bus.enablen),     32'd1);
        check("rst_pulse",   32'(bus.tecla_pulso), 32'd0);
        bus.loadn = 1'b1;
        reset     = 1'b0;
        cycles(10);
        check("idle_enablen", 32'(bus.enablen), 32'd0);

        // Single key 5; edges counted from the first edge that samples loadn low.
        pulse_cnt     = 0;
        bus.loadn     = 1'b0;
        bus.saida_cod = 4'd5;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.tecla_pulso === 1'b1 && lat < 0) lat = k;
        end
        cycles(4);
        bus.loadn = 1'b1;
        cycles(10);
        check("single_latency", 32'(lat),             32'd7);
        check("single_tempo",   32'(bus.tempo_bcd),   32'h0005);
        check("single_num",     32'(bus.num_digitos), 32'd1);
        check("single_pulses",  32'(pulse_cnt),       32'd1);

        // Bounce: low 2, high 1, low 2, high -> rejected.
        pulse_cnt     = 0;
        bus.saida_cod = 4'd8;
        bus.loadn = 1'b0; cycles(2);
        bus.loadn = 1'b1; cycles(1);
        bus.loadn = 1'b0; cycles(2);
        bus.loadn = 1'b1; cycles(15);
        check("bounce_tempo",  32'(bus.tempo_bcd),   32'h0005);
        check("bounce_num",    32'(bus.num_digitos), 32'd1);
        check("bounce_pulses", 32'(pulse_cnt),       32'd0);

        // Plain clear, then a non-digit key is consumed silently.
        do_clear();
        check("clr_tempo", 32'(bus.tempo_bcd),   32'h0);
        check("clr_num",   32'(bus.num_digitos), 32'd0);
        pulse_cnt = 0;
        press_key(4'hB, 10, 10);
        check("nondigit_tempo",  32'(bus.tempo_bcd), 32'h0);
        check("nondigit_pulses", 32'(pulse_cnt),     32'd0);

        // Sequence 1,2,3,4 fills the register; 9 is then ignored.
        press_key(4'd1, 10, 10);
        press_key(4'd2, 10, 10);
        press_key(4'd3, 10, 10);
        press_key(4'd4, 10, 10);
        check("seq_tempo",  32'(bus.tempo_bcd),   32'h1234);
        check("seq_num",    32'(bus.num_digitos), 32'd4);
        check("seq_cheio",  32'(bus.cheio),       32'd1);
        check("seq_pulses", 32'(pulse_cnt),       32'd4);
        press_key(4'd9, 10, 10);
        check("full_tempo",  32'(bus.tempo_bcd),   32'h1234);
        check("full_num",    32'(bus.num_digitos), 32'd4);
        check("full_pulses", 32'(pulse_cnt),       32'd4);

        // Clear raised in the CAPTURE cycle of key 7 with 12 already entered.
        do_clear();
        press_key(4'd1, 10, 10);
        press_key(4'd2, 10, 10);
        check("pre7_tempo", 32'(bus.tempo_bcd), 32'h0012);
        pulse_cnt     = 0;
        bus.loadn     = 1'b0;
        bus.saida_cod = 4'd7;
        cycles(7);
        bus.clear = 1'b1;
        cycles(1);
        bus.clear = 1'b0;
        cycles(5);
        bus.loadn = 1'b1;
        cycles(10);
        check("clr7_tempo",  32'(bus.tempo_bcd),   32'h0);
        check("clr7_num",    32'(bus.num_digitos), 32'd0);
        check("clr7_cheio",  32'(bus.cheio),       32'd0);
        check("clr7_pulses", 32'(pulse_cnt),       32'd0);

        // Lock raised during DEB_PRESS of key 8; entered time is held.
        press_key(4'd3, 10, 10);
        pulse_cnt     = 0;
        bus.loadn     = 1'b0;
        bus.saida_cod = 4'd8;
        cycles(4);
        check("prelock_enablen", 32'(bus.enablen), 32'd0);
        bus.lock = 1'b1;
        cycles(1);
        check("lock_enablen", 32'(bus.enablen), 32'd1);
        cycles(8);
        bus.lock = 1'b0;
        cycles(1);
        check("unlock_enablen", 32'(bus.enablen), 32'd0);
        bus.loadn = 1'b1;
        cycles(10);
        check("lock_tempo",  32'(bus.tempo_bcd), 32'h0003);
        check("lock_pulses", 32'(pulse_cnt),     32'd0);
        press_key(4'd6, 10, 10);
        check("after_lock_tempo",  32'(bus.tempo_bcd),   32'h0036);
        check("after_lock_num",    32'(bus.num_digitos), 32'd2);
        check("after_lock_pulses", 32'(pulse_cnt),       32'd1);

        // Leading zeros count: 0,0,3,0 -> 00:30.
        do_clear();
        press_key(4'd0, 10, 10);
        press_key(4'd0, 10, 10);
        press_key(4'd3, 10, 10);
        press_key(4'd0, 10, 10);
        check("zeros_tempo", 32'(bus.tempo_bcd),   32'h0030);
        check("zeros_num",   32'(bus.num_digitos), 32'd4);
        check("zeros_cheio", 32'(bus.cheio),       32'd1);

        // Reset in the middle of a press wipes everything.
        pulse_cnt     = 0;
        bus.loadn     = 1'b0;
        bus.saida_cod = 4'd9;
        bus.lock      = 1'b1;
        cycles(1);
        bus.lock = 1'b0;
        cycles(3);
        reset     = 1'b1;
        bus.loadn = 1'b1;
        cycles(1);
        check("midrst_tempo",   32'(bus.tempo_bcd),   32'h0);
        check("midrst_num",     32'(bus.num_digitos), 32'd0);
        check("midrst_enablen", 32'(bus.enablen),     32'd1);
        reset = 1'b0;
        cycles(12);
        check("postrst_num",    32'(bus.num_digitos), 32'd0);
        check("postrst_pulses", 32'(pulse_cnt),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
